psum_drain_fifo: RTL and testbench



---
 rtl/cnn_pkg.sv | 24 ++
 rtl/quant_relu_sat.sv | 36 +++
 rtl/psum_drain_fifo.sv | 167 ++++++++++++++++
 tb/tb_psum_drain_fifo.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: default widths, saturation
// limit helpers and the drain serialiser state encoding.
`timescale 1ns/1ps
package cnn_pkg;

  localparam int ACC_W_DEF  = 16;
  localparam int DATA_W_DEF = 8;

  // Largest value representable in a signed dw-bit word.
  function automatic int sat_max(input int dw);
    return (1 << (dw - 1)) - 1;
  endfunction

  // Smallest value representable in a signed dw-bit word.
  function automatic int sat_min(input int dw);
    return -(1 << (dw - 1));
  endfunction

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SERIAL = 1'b1
  } drain_state_e;

endpackage

// File: rtl/quant_relu_sat.sv
// Combinational quantiser: arithmetic right shift, optional ReLU, then
// saturation of the ACC_W-bit result into a signed DATA_W-bit word.
`timescale 1ns/1ps
module quant_relu_sat
  import cnn_pkg::*;
#(
  parameter int ACC_W  = ACC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic signed [ACC_W-1:0]  i_acc,
  input  logic        [3:0]        i_shift,
  input  logic                     i_relu_en,
  output logic signed [DATA_W-1:0] o_q
);

  localparam logic signed [ACC_W-1:0] LIM_MAX = ACC_W'(sat_max(DATA_W));
  localparam logic signed [ACC_W-1:0] LIM_MIN = ACC_W'(sat_min(DATA_W));

  logic signed [ACC_W-1:0] w_shifted;
  logic signed [ACC_W-1:0] w_relu;

  // Shift keeps the sign; ReLU clamps before the range check so a clamped
  // value can never saturate low.
  always_comb begin
    w_shifted = i_acc >>> i_shift;
    w_relu    = (i_relu_en && (w_shifted < 0)) ? '0 : w_shifted;
    if (w_relu > LIM_MAX) begin
      o_q = LIM_MAX[DATA_W-1:0];
    end else if (w_relu < LIM_MIN) begin
      o_q = LIM_MIN[DATA_W-1:0];
    end else begin
      o_q = w_relu[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/psum_drain_fifo.sv
// Drain stage between the systolic array and output_fill1: captures one
// row of accumulators, quantises and serialises it one column per cycle
// into a circular FIFO that the downstream stage pops.
`timescale 1ns/1ps
module psum_drain_fifo
  import cnn_pkg::*;
#(
  parameter int ACC_W    = ACC_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_COLS = 4,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                      w_clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      relu_en,
  input  logic [3:0]                shift,
  input  logic                      drain_valid,
  input  logic [NUM_COLS*ACC_W-1:0] drain_data,
  output logic                      drain_ready,
  input  logic                      read_enable,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      is_empty,
  output logic                      is_full,
  output logic [AW:0]               count
);

  localparam int            CW       = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(NUM_COLS - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  drain_state_e            r_state;
  logic [CW-1:0]           r_col_idx;
  logic signed [ACC_W-1:0] r_row [NUM_COLS];
  logic signed [ACC_W-1:0] w_col [NUM_COLS];

  logic [DATA_W-1:0]       r_mem [DEPTH];
  logic [AW-1:0]           r_wr_ptr;
  logic [AW-1:0]           r_rd_ptr;
  logic [AW:0]             r_count;
  logic [AW:0]             w_count_next;
  logic                    r_empty;
  logic                    r_full;
  logic                    r_rd_valid;
  logic [DATA_W-1:0]       r_rd_data;

  logic                    w_capture;
  logic                    w_push;
  logic                    w_pop;
  logic signed [DATA_W-1:0] w_q;

  // Unpack the flat drain bus, column 0 in the LSBs.
  generate
    for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_unpack
      assign w_col[gi] = drain_data[gi*ACC_W +: ACC_W];
    end
  endgenerate

  // Ready is gated by reset so nothing is offered while the block is held.
  assign drain_ready = reset && (r_state == ST_IDLE) && enable;
  assign w_capture   = drain_ready && drain_valid;
  // Full is the pre-edge flag, so a same-cycle pop never frees a slot early.
  assign w_push      = reset && (r_state == ST_SERIAL) && enable && !r_full;
  assign w_pop       = reset && read_enable && !r_empty;

  quant_relu_sat #(
    .ACC_W  (ACC_W),
    .DATA_W (DATA_W)
  ) u_quant (
    .i_acc     (r_row[r_col_idx]),
    .i_shift   (shift),
    .i_relu_en (relu_en),
    .o_q       (w_q)
  );

  // Serialiser FSM: capture a row in IDLE, push one column per enabled
  // non-full cycle in SERIAL, return to IDLE after the last column.
  always_ff @(posedge w_clk) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_col_idx <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_capture) begin
            r_col_idx <= '0;
            r_state   <= ST_SERIAL;
          end
        end
        ST_SERIAL: begin
          if (w_push) begin
            if (r_col_idx == LAST_COL) begin
              r_col_idx <= '0;
              r_state   <= ST_IDLE;
            end else begin
              r_col_idx <= r_col_idx + CW'(1);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_col_idx <= '0;
        end
      endcase
    end
  end

  // Row holding register; contents are only meaningful while SERIAL.
  always_ff @(posedge w_clk) begin
    if (w_capture) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        r_row[c] <= w_col[c];
      end
    end
  end

  // FIFO storage write port.
  always_ff @(posedge w_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_q;
    end
  end

  // Occupancy after this edge, used to register the status flags.
  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Pointers, occupancy, status flags and the registered read port.
  always_ff @(posedge w_clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        r_rd_data <= r_mem[r_rd_ptr];
      end
      r_rd_valid <= w_pop;
      r_count    <= w_count_next;
      r_empty    <= (w_count_next == '0);
      r_full     <= (w_count_next == FULL_CNT);
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign is_empty = r_empty;
  assign is_full  = r_full;
  assign count    = r_count;

endmodule

// File: tb/tb_psum_drain_fifo.sv
// Directed bench for psum_drain_fifo: quantiser, serialiser stall,
// FIFO full/empty/wrap behaviour, enable freeze and mid-row reset.
`timescale 1ns/1ps
module tb_psum_drain_fifo;

  localparam int ACC_W    = 16;
  localparam int DATA_W   = 8;
  localparam int NUM_COLS = 4;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;

  logic                      w_clk;
  logic                      reset;
  logic                      enable;
  logic                      relu_en;
  logic [3:0]                shift;
  logic                      drain_valid;
  logic [NUM_COLS*ACC_W-1:0] drain_data;
  logic                      drain_ready;
  logic                      read_enable;
  logic [DATA_W-1:0]         rd_data;
  logic                      rd_valid;
  logic                      is_empty;
  logic                      is_full;
  logic [AW:0]               count;

  int n_cmp  = 0;
  int n_fail = 0;

  psum_drain_fifo #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .NUM_COLS (NUM_COLS),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) dut (
    .w_clk       (w_clk),
    .reset       (reset),
    .enable      (enable),
    .relu_en     (relu_en),
    .shift       (shift),
    .drain_valid (drain_valid),
    .drain_data  (drain_data),
    .drain_ready (drain_ready),
    .read_enable (read_enable),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .is_empty    (is_empty),
    .is_full     (is_full),
    .count       (count)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    #1;
  endtask

  task automatic send_row(input int c0, input int c1, input int c2, input int c3);
    bit got;
    got = 1'b0;
    drain_data  = {16'(c3), 16'(c2), 16'(c1), 16'(c0)};
    drain_valid = 1'b1;
    #1;
    for (int i = 0; i < 64; i++) begin
      if (drain_ready) begin
        got = 1'b1;
        break;
      end
      tick();
      #1;
    end
    tick();
    drain_valid = 1'b0;
    if (!got) chk("row_accept_timeout", 0, 1);
    $display("row  {%0d,%0d,%0d,%0d} offered, accepted=%0d", c0, c1, c2, c3, got);
  endtask

  task automatic pop_chk(input string tag, input int exp);
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    $display("pop  %s rd_valid=%0d rd_data=%0d count=%0d", tag, rd_valid,
             $signed(rd_data), count);
    chk({tag, "_valid"}, rd_valid, 1);
    chk({tag, "_data"}, $signed(rd_data), exp);
  endtask

  initial begin
    int exp3[19];
    reset       = 1'b0;
    enable      = 1'b0;
    relu_en     = 1'b0;
    shift       = 4'd0;
    drain_valid = 1'b0;
    drain_data  = '0;
    read_enable = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_drain_ready", drain_ready, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_is_empty", is_empty, 1);
    chk("rst_is_full", is_full, 0);
    chk("rst_count", count, 0);
    reset  = 1'b1;
    enable = 1'b1;
    tick();

    // Basic row: saturation both ways
    send_row(5, -3, 200, -300);
    chk("t1_count_capture", count, 0);
    tick(); tick(); tick(); tick();
    chk("t1_count_4", count, 4);
    pop_chk("t1_p0", 5);
    pop_chk("t1_p1", -3);
    pop_chk("t1_p2", 127);
    pop_chk("t1_p3", -128);
    chk("t1_empty", is_empty, 1);
    tick();
    chk("t1_valid_low", rd_valid, 0);

    // ReLU and shift
    shift   = 4'd2;
    relu_en = 1'b1;
    send_row(-8, 12, 1000, 3);
    tick(); tick(); tick(); tick();
    pop_chk("t2_p0", 0);
    pop_chk("t2_p1", 3);
    pop_chk("t2_p2", 127);
    pop_chk("t2_p3", 0);
    chk("t2_empty", is_empty, 1);
    shift   = 4'd0;
    relu_en = 1'b0;

    // Fill to full, stall the fifth row, then drain everything
    send_row(1, 2, 3, 4);
    send_row(11, 12, 13, 14);
    send_row(21, 22, 23, 24);
    send_row(31, 32, 33, 34);
    tick(); tick(); tick(); tick();
    chk("t3_count_full", count, 16);
    chk("t3_is_full", is_full, 1);
    send_row(41, 42, 43, 44);
    tick(); tick(); tick();
    chk("t3_stall_count", count, 16);
    chk("t3_stall_ready", drain_ready, 0);
    chk("t3_stall_col", dut.r_col_idx, 0);
    pop_chk("t3_first", 1);
    chk("t3_count_after_pop", count, 15);
    tick();
    chk("t3_count_refill", count, 16);
    chk("t3_col_after_refill", dut.r_col_idx, 1);
    tick();
    chk("t3_count_hold", count, 16);
    chk("t3_col_hold", dut.r_col_idx, 1);
    exp3 = '{2, 3, 4, 11, 12, 13, 14, 21, 22, 23, 24, 31, 32, 33, 34, 41, 42, 43, 44};
    for (int i = 0; i < 19; i++) begin
      pop_chk($sformatf("t3_d%0d", i), exp3[i]);
    end
    chk("t3_empty", is_empty, 1);
    chk("t3_count_zero", count, 0);
    chk("t3_ready_idle", drain_ready, 1);

    // Concurrent push/pop at count 3, pointers wrap past entry 15
    send_row(1, 2, 3, 4);
    tick(); tick(); tick(); tick();
    chk("t4_count_4", count, 4);
    pop_chk("t4_pre", 1);
    chk("t4_count_3", count, 3);
    send_row(5, 6, 7, 8);
    read_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("pop  t4_c%0d rd_valid=%0d rd_data=%0d count=%0d", i, rd_valid,
               $signed(rd_data), count);
      chk($sformatf("t4_c%0d_count", i), count, 3);
      chk($sformatf("t4_c%0d_valid", i), rd_valid, 1);
      chk($sformatf("t4_c%0d_data", i), $signed(rd_data), 2 + i);
    end
    read_enable = 1'b0;
    pop_chk("t4_p6", 6);
    pop_chk("t4_p7", 7);
    pop_chk("t4_p8", 8);
    chk("t4_empty", is_empty, 1);

    // Read while empty is ignored
    read_enable = 1'b1;
    tick();
    read_enable = 1'b0;
    $display("pop  t5_empty rd_valid=%0d rd_data=%0d count=%0d", rd_valid,
             $signed(rd_data), count);
    chk("t5_empty_valid", rd_valid, 0);
    chk("t5_empty_count", count, 0);
    chk("t5_empty_hold", $signed(rd_data), 8);
    chk("t5_empty_flag", is_empty, 1);

    // Enable low mid-row freezes the serialiser, pops still served
    send_row(9, 10, 11, 12);
    tick(); tick();
    chk("t5_count_2", count, 2);
    enable = 1'b0;
    tick(); tick(); tick();
    chk("t5_frozen_count", count, 2);
    chk("t5_frozen_col", dut.r_col_idx, 2);
    chk("t5_frozen_ready", drain_ready, 0);
    pop_chk("t5_p9", 9);
    chk("t5_pop_count", count, 1);
    chk("t5_pop_col", dut.r_col_idx, 2);
    enable = 1'b1;
    tick(); tick();
    chk("t5_resume_count", count, 3);
    chk("t5_resume_ready", drain_ready, 1);
    pop_chk("t5_p10", 10);
    pop_chk("t5_p11", 11);
    pop_chk("t5_p12", 12);
    chk("t5_end_empty", is_empty, 1);
    enable = 1'b0;
    #1;
    chk("t5_idle_ready_dis", drain_ready, 0);
    enable = 1'b1;

    // Reset after two of four pushes
    send_row(21, 22, 23, 24);
    tick(); tick();
    chk("t6_count_2", count, 2);
    reset = 1'b0;
    #1;
    chk("t6_ready_in_reset", drain_ready, 0);
    tick();
    chk("t6_count", count, 0);
    chk("t6_empty", is_empty, 1);
    chk("t6_full", is_full, 0);
    chk("t6_rd_data", rd_data, 0);
    chk("t6_state", dut.r_state, 0);
    chk("t6_ready_held", drain_ready, 0);
    reset = 1'b1;
    #1;
    chk("t6_ready_after", drain_ready, 1);
    tick();
    chk("t6_count_after", count, 0);
    send_row(31, -32, 33, -34);
    tick(); tick(); tick(); tick();
    chk("t6_count_4", count, 4);
    pop_chk("t6_p0", 31);
    pop_chk("t6_p1", -32);
    pop_chk("t6_p2", 33);
    pop_chk("t6_p3", -34);
    chk("t6_final_empty", is_empty, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
